// File: rtl/async_sync_pkg.sv
// Shared constants and helpers for the multi-channel async input synchroniser.
// Optional edge-pulse outputs are enabled by defining ASYNC_SYNC_EDGE_EN.
package async_sync_pkg;

  localparam int STAGES_MIN        = 2;
  localparam int FILTER_CYCLES_MIN = 1;

  // Counter must be able to hold 0..FILTER_CYCLES-1.
  function automatic int cnt_w(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/async_sync_chan.sv
// One channel: synchroniser chain, stability filter and registered clean level.
// With ASYNC_SYNC_EDGE_EN defined, also registered rise/fall pulses.
module async_sync_chan
  import async_sync_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d_async_i,
  output logic d_sync_o
`ifdef ASYNC_SYNC_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int CNT_W = cnt_w(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [STAGES-1:0] sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              upd;
  logic              sync_bit;

  assign sync_bit = sync_q[STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_BIT}};
      cnt_q  <= '0;
      out_q  <= RESET_BIT;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_async_i};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  // Any matching cycle clears the run, so short glitches never reach the output.
  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    upd   = 1'b0;
    if (sync_bit != out_q) begin
      if (cnt_q == CNT_LAST) begin
        out_d = sync_bit;
        upd   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  assign d_sync_o = out_q;

`ifdef ASYNC_SYNC_EDGE_EN
  logic rise_q, fall_q;

  // Pulses come from the update decision, so they line up with the new level.
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= upd & sync_bit;
      fall_q <= upd & ~sync_bit;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/async_input_sync.sv
// Multi-channel asynchronous input synchroniser with glitch filter.
// Define ASYNC_SYNC_EDGE_EN to add the data_rise/data_fall pulse outputs.
module async_input_sync
  import async_sync_pkg::*;
#(
  parameter int                  CHANNELS      = 8,
  parameter int                  STAGES        = 2,
  parameter int                  FILTER_CYCLES = 4,
  parameter logic [CHANNELS-1:0] RESET_VAL     = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] data_async,
  output logic [CHANNELS-1:0] data_sync
`ifdef ASYNC_SYNC_EDGE_EN
  ,
  output logic [CHANNELS-1:0] data_rise,
  output logic [CHANNELS-1:0] data_fall
`endif
);

  if (CHANNELS < 1) begin : g_err_channels
    $error("async_input_sync: CHANNELS must be >= 1");
  end
  if (STAGES < STAGES_MIN) begin : g_err_stages
    $error("async_input_sync: STAGES must be >= 2");
  end
  if (FILTER_CYCLES < FILTER_CYCLES_MIN) begin : g_err_filter
    $error("async_input_sync: FILTER_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    async_sync_chan #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VAL[i])
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .d_async_i (data_async[i]),
      .d_sync_o  (data_sync[i])
`ifdef ASYNC_SYNC_EDGE_EN
      ,
      .rise_o    (data_rise[i]),
      .fall_o    (data_fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_async_input_sync.sv
// Self-checking bench for async_input_sync: directed scenarios plus random toggling,
// compared against a cycle-level reference of the synchroniser/filter rules.
module tb_async_input_sync #(
  parameter int STAGES        = 2,
  parameter int FILTER_CYCLES = 4
);

  localparam int CH = 8;
  localparam logic [CH-1:0] RV = '0;

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] data_async;
  logic [CH-1:0] data_sync;
`ifdef ASYNC_SYNC_EDGE_EN
  logic [CH-1:0] data_rise;
  logic [CH-1:0] data_fall;
`endif

  async_input_sync #(
    .CHANNELS      (CH),
    .STAGES        (STAGES),
    .FILTER_CYCLES (FILTER_CYCLES),
    .RESET_VAL     (RV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .data_async (data_async),
    .data_sync  (data_sync)
`ifdef ASYNC_SYNC_EDGE_EN
    ,
    .data_rise  (data_rise),
    .data_fall  (data_fall)
`endif
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: history of sampled inputs plus per-channel mismatch run length.
  logic [CH-1:0] hist [STAGES];
  logic [CH-1:0] m_level, m_rise, m_fall;
  int            run [CH];

  task automatic model_tick();
    logic [CH-1:0] seen;
    if (reset) begin
      for (int k = 0; k < STAGES; k++) hist[k] = RV;
      m_level = RV;
      m_rise  = '0;
      m_fall  = '0;
      for (int c = 0; c < CH; c++) run[c] = 0;
    end else begin
      seen   = hist[STAGES-1];
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        if (seen[c] !== m_level[c]) begin
          run[c] = run[c] + 1;
          if (run[c] >= FILTER_CYCLES) begin
            m_level[c] = seen[c];
            run[c] = 0;
            if (seen[c]) m_rise[c] = 1'b1;
            else         m_fall[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
      end
      for (int k = STAGES - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = data_async;
    end
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_tick();
    @(negedge clock);
    chk("sync_vs_model", data_sync, m_level);
`ifdef ASYNC_SYNC_EDGE_EN
    chk("rise_vs_model", data_rise, m_rise);
    chk("fall_vs_model", data_fall, m_fall);
`endif
  endtask

  task automatic settle();
    repeat (STAGES + 2 * FILTER_CYCLES + 2) step();
  endtask

  int lat;
  logic [CH-1:0] mask;

  initial begin
    // 1: reset with all inputs high
    reset      = 1'b1;
    data_async = 8'hFF;
    repeat (3) begin
      step();
      chk("reset_sync", data_sync, RV);
    end
    reset = 1'b0;
    step();
    chk("post_release_sync", data_sync, RV);
`ifdef ASYNC_SYNC_EDGE_EN
    chk("post_release_rise", data_rise, '0);
    chk("post_release_fall", data_fall, '0);
`endif
    data_async = '0;
    settle();
    chk("idle_sync", data_sync, 8'h00);

    // 2: clean step on ch0, latency measured from the first capturing edge
    data_async[0] = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (data_sync[0]) break;
    end
    chk_int("step_latency", lat, STAGES + FILTER_CYCLES);
`ifdef ASYNC_SYNC_EDGE_EN
    chk("step_rise", data_rise, 8'h01);
    step();
    chk("step_rise_done", data_rise, 8'h00);
`endif
    settle();

    // 3: glitch one cycle too short is rejected, full-length pulse is accepted
    data_async[3] = 1'b1;
    repeat (FILTER_CYCLES - 1) step();
    data_async[3] = 1'b0;
    settle();
    chk("glitch_reject", data_sync & 8'h08, 8'h00);
    data_async[3] = 1'b1;
    repeat (FILTER_CYCLES) step();
    data_async[3] = 1'b0;
    repeat (STAGES) step();
    chk("glitch_accept", data_sync & 8'h08, 8'h08);
    settle();
    chk("glitch_return", data_sync & 8'h08, 8'h00);

    // 4: simultaneous rise on ch1 and fall on ch2
    data_async[2] = 1'b1;
    settle();
    chk("ch2_high", data_sync & 8'h06, 8'h04);
    data_async[1] = 1'b1;
    data_async[2] = 1'b0;
    repeat (STAGES + FILTER_CYCLES) step();
    chk("simul_sync", data_sync & 8'h06, 8'h02);
`ifdef ASYNC_SYNC_EDGE_EN
    chk("simul_rise", data_rise, 8'h02);
    chk("simul_fall", data_fall, 8'h04);
    step();
    chk("simul_rise_done", data_rise, 8'h00);
    chk("simul_fall_done", data_fall, 8'h00);
`endif
    settle();

    // 5: reset while ch5 is part-way through its filter run
    data_async[5] = 1'b1;
    repeat (STAGES + 2) step();
    reset = 1'b1;
    step();
    chk("midfilt_reset_sync", data_sync, RV);
`ifdef ASYNC_SYNC_EDGE_EN
    chk("midfilt_reset_rise", data_rise, '0);
`endif
    reset = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      lat++;
      if (data_sync[5]) break;
    end
    chk_int("midfilt_latency", lat, STAGES + FILTER_CYCLES);
    settle();

    // Random toggling with sparse masks and occasional resets
    for (int i = 0; i < 600; i++) begin
      mask = CH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) data_async = data_async ^ mask;
      reset = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0;
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
